// File: rtl/fetch_queue_stage.sv
// Decoupled fetch stage: a DEPTH-entry circular FIFO of {pc, instr, pred}
// between the fetch unit and the scoreboard. A flush empties the queue and
// drops fetches until the corrected PC arrives. A halt empties the queue and
// stays in effect until reset.
module fetch_queue_stage #(
  parameter int WORD_W = 32,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_pc,
  input  logic [WORD_W-1:0] in_instr,
  input  logic              in_pred,
  output logic              in_ready,
  output logic              out_valid,
  output logic [WORD_W-1:0] out_pc,
  output logic [WORD_W-1:0] out_instr,
  output logic              out_pred,
  input  logic              out_ready,
  input  logic              flush,
  input  logic [WORD_W-1:0] flush_pc,
  input  logic              halt,
  output logic              squashing,
  output logic [CNT_W-1:0]  count
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_SQUASH = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [WORD_W-1:0]   target_q, target_d;

  logic [WORD_W-1:0]   pc_mem_q    [DEPTH];
  logic [WORD_W-1:0]   instr_mem_q [DEPTH];
  logic                pred_mem_q  [DEPTH];

  logic                enq;
  logic                deq;

  // Handshakes, forced output bubble, and next-state for the control registers.
  always_comb begin
    state_d   = state_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    target_d  = target_q;
    enq       = 1'b0;
    deq       = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    squashing = (state_q == ST_SQUASH);

    case (state_q)
      ST_RUN:    in_ready = (count_q < CNT_W'(DEPTH));
      ST_SQUASH: in_ready = 1'b1;
      default:   in_ready = 1'b0;
    endcase

    // Head is hidden during a flush or halt cycle so no wrong-path op issues.
    out_valid = (state_q != ST_HALTED) && (count_q != '0) && !flush && !halt;

    if (halt) begin
      state_d  = ST_HALTED;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else if (flush && (state_q != ST_HALTED)) begin
      state_d  = ST_SQUASH;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      target_d = flush_pc;
    end else begin
      case (state_q)
        ST_RUN: begin
          enq = in_valid && in_ready;
          deq = out_valid && out_ready;
        end
        ST_SQUASH: begin
          // Queue is empty here, so only the matching beat is of interest.
          enq = in_valid && (in_pc == target_q);
          if (enq) state_d = ST_RUN;
        end
        default: ;
      endcase
      if (enq) wr_ptr_d = wr_ptr_q + 1'b1;
      if (deq) rd_ptr_d = rd_ptr_q + 1'b1;
      if (enq && !deq)      count_d = count_q + CNT_W'(1);
      else if (!enq && deq) count_d = count_q - CNT_W'(1);
    end
  end

  // Control state register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= ST_RUN;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      target_q <= target_d;
    end
  end

  // One storage slot per entry, written only when it is the enqueue target.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
        pc_mem_q[gi]    <= '0;
        instr_mem_q[gi] <= '0;
        pred_mem_q[gi]  <= 1'b0;
      end else if (enq && (wr_ptr_q == PTR_W'(gi))) begin
        pc_mem_q[gi]    <= in_pc;
        instr_mem_q[gi] <= in_instr;
        pred_mem_q[gi]  <= in_pred;
      end
    end
  end

  // Head outputs come from storage only and read as zero when not valid.
  always_comb begin
    out_pc    = '0;
    out_instr = '0;
    out_pred  = 1'b0;
    if (out_valid) begin
      out_pc    = pc_mem_q[rd_ptr_q];
      out_instr = instr_mem_q[rd_ptr_q];
      out_pred  = pred_mem_q[rd_ptr_q];
    end
  end

  assign count = count_q;

endmodule

// File: tb/tb_fetch_queue_stage.sv
// Directed bench for fetch_queue_stage: fill/drain, freeze, flush/squash,
// re-flush, halt priority and asynchronous reset.
module tb_fetch_queue_stage;

  localparam int WORD_W = 32;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic              CLK = 1'b0;
  logic              nRST;
  logic              in_valid;
  logic [WORD_W-1:0] in_pc;
  logic [WORD_W-1:0] in_instr;
  logic              in_pred;
  logic              in_ready;
  logic              out_valid;
  logic [WORD_W-1:0] out_pc;
  logic [WORD_W-1:0] out_instr;
  logic              out_pred;
  logic              out_ready;
  logic              flush;
  logic [WORD_W-1:0] flush_pc;
  logic              halt;
  logic              squashing;
  logic [CNT_W-1:0]  count;

  int checks_cnt = 0;
  int fail_cnt   = 0;

  fetch_queue_stage #(.WORD_W(WORD_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .nRST(nRST),
    .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr), .in_pred(in_pred),
    .in_ready(in_ready),
    .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr), .out_pred(out_pred),
    .out_ready(out_ready),
    .flush(flush), .flush_pc(flush_pc), .halt(halt),
    .squashing(squashing), .count(count)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, obs);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic beat(input logic [31:0] pc, input logic [31:0] instr, input logic pred);
    in_valid = 1'b1;
    in_pc    = pc;
    in_instr = instr;
    in_pred  = pred;
  endtask

  task automatic idle_in();
    in_valid = 1'b0;
    in_pc    = '0;
    in_instr = '0;
    in_pred  = 1'b0;
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    #7;
    nRST = 1'b1;
    step();
  endtask

  initial begin
    idle_in();
    out_ready = 1'b0;
    flush     = 1'b0;
    flush_pc  = '0;
    halt      = 1'b0;
    nRST      = 1'b0;
    #3;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_pc", out_pc, 32'd0);
    chk("rst_squashing", {31'd0, squashing}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_count", {29'd0, count}, 32'd0);
    #4;
    nRST = 1'b1;
    step();

    // Fill with the scoreboard frozen, then drain in order.
    for (int i = 0; i < 4; i++) begin
      beat(i * 4, 32'hA000 + i, i[0]);
      step();
    end
    beat(32'h10, 32'hA004, 1'b0);
    chk("fill_count", {29'd0, count}, 32'd4);
    chk("fill_in_ready", {31'd0, in_ready}, 32'd0);
    step();
    chk("fifth_dropped_count", {29'd0, count}, 32'd4);
    idle_in();
    out_ready = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain%0d_valid", i), {31'd0, out_valid}, 32'd1);
      chk($sformatf("drain%0d_pc", i), out_pc, i * 4);
      chk($sformatf("drain%0d_instr", i), out_instr, 32'hA000 + i);
      chk($sformatf("drain%0d_pred", i), {31'd0, out_pred}, {31'd0, i[0]});
      step();
    end
    chk("drained_count", {29'd0, count}, 32'd0);
    chk("drained_out_pc", out_pc, 32'd0);
    chk("drained_out_valid", {31'd0, out_valid}, 32'd0);

    // Freeze: head must hold while out_ready is low.
    out_ready = 1'b0;
    beat(32'h10, 32'hB010, 1'b1);
    step();
    idle_in();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("freeze%0d_pc", i), out_pc, 32'h10);
      chk($sformatf("freeze%0d_instr", i), out_instr, 32'hB010);
      chk($sformatf("freeze%0d_count", i), {29'd0, count}, 32'd1);
      step();
    end
    out_ready = 1'b1;
    step();
    chk("freeze_release_count", {29'd0, count}, 32'd0);
    out_ready = 1'b0;

    // Flush with three queued entries, then squash until 0x40 shows up.
    for (int i = 0; i < 3; i++) begin
      beat(i * 4, 32'hC000 + i, 1'b0);
      step();
    end
    chk("preflush_count", {29'd0, count}, 32'd3);
    beat(32'h0C, 32'hC003, 1'b0);
    out_ready = 1'b1;
    flush     = 1'b1;
    flush_pc  = 32'h40;
    #1;
    chk("flush_cycle_out_valid", {31'd0, out_valid}, 32'd0);
    step();
    flush = 1'b0;
    out_ready = 1'b0;
    chk("post_flush_count", {29'd0, count}, 32'd0);
    chk("post_flush_squashing", {31'd0, squashing}, 32'd1);
    chk("squash_in_ready", {31'd0, in_ready}, 32'd1);
    beat(32'h0C, 32'hC003, 1'b0);
    step();
    chk("squash_drop_0c", {29'd0, count}, 32'd0);
    beat(32'h10, 32'hC004, 1'b0);
    step();
    chk("squash_drop_10", {29'd0, count}, 32'd0);
    chk("squash_still", {31'd0, squashing}, 32'd1);
    beat(32'h40, 32'hC040, 1'b1);
    step();
    idle_in();
    chk("squash_exit", {31'd0, squashing}, 32'd0);
    chk("squash_accept_count", {29'd0, count}, 32'd1);
    chk("squash_out_pc", out_pc, 32'h40);
    chk("squash_out_instr", out_instr, 32'hC040);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("squash_drain_count", {29'd0, count}, 32'd0);

    // Re-flush during SQUASH retargets to the newer PC.
    flush = 1'b1;
    flush_pc = 32'h40;
    step();
    flush_pc = 32'h80;
    step();
    flush = 1'b0;
    beat(32'h40, 32'hD040, 1'b0);
    step();
    chk("reflush_drop_40", {29'd0, count}, 32'd0);
    chk("reflush_squashing", {31'd0, squashing}, 32'd1);
    beat(32'h80, 32'hD080, 1'b0);
    step();
    idle_in();
    chk("reflush_accept_count", {29'd0, count}, 32'd1);
    chk("reflush_out_pc", out_pc, 32'h80);
    chk("reflush_squash_exit", {31'd0, squashing}, 32'd0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Halt together with flush: halt wins and sticks.
    beat(32'h100, 32'hE100, 1'b0);
    step();
    beat(32'h104, 32'hE104, 1'b0);
    step();
    idle_in();
    chk("prehalt_count", {29'd0, count}, 32'd2);
    chk("prehalt_out_valid", {31'd0, out_valid}, 32'd1);
    halt = 1'b1;
    flush = 1'b1;
    flush_pc = 32'h200;
    out_ready = 1'b1;
    #1;
    chk("halt_cycle_out_valid", {31'd0, out_valid}, 32'd0);
    chk("halt_cycle_out_pc", out_pc, 32'd0);
    step();
    halt = 1'b0;
    flush = 1'b0;
    chk("halted_in_ready", {31'd0, in_ready}, 32'd0);
    chk("halted_out_valid", {31'd0, out_valid}, 32'd0);
    chk("halted_squashing", {31'd0, squashing}, 32'd0);
    chk("halted_count", {29'd0, count}, 32'd0);
    beat(32'h300, 32'hE300, 1'b0);
    flush = 1'b1;
    flush_pc = 32'h300;
    step();
    flush = 1'b0;
    step();
    chk("halted_sticky_in_ready", {31'd0, in_ready}, 32'd0);
    chk("halted_sticky_out_valid", {31'd0, out_valid}, 32'd0);
    chk("halted_sticky_count", {29'd0, count}, 32'd0);
    chk("halted_sticky_squashing", {31'd0, squashing}, 32'd0);
    idle_in();
    out_ready = 1'b0;

    // Asynchronous reset between edges with three entries queued.
    do_reset();
    chk("rerun_in_ready", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      beat(32'h500 + i * 4, 32'hF000 + i, 1'b1);
      step();
    end
    idle_in();
    chk("prereset_count", {29'd0, count}, 32'd3);
    chk("prereset_out_pc", out_pc, 32'h500);
    #2;
    nRST = 1'b0;
    #1;
    chk("async_out_valid", {31'd0, out_valid}, 32'd0);
    chk("async_out_pc", out_pc, 32'd0);
    chk("async_out_instr", out_instr, 32'd0);
    chk("async_count", {29'd0, count}, 32'd0);
    chk("async_in_ready", {31'd0, in_ready}, 32'd1);
    chk("async_squashing", {31'd0, squashing}, 32'd0);
    #3;
    nRST = 1'b1;
    step();
    beat(32'h600, 32'hF600, 1'b0);
    step();
    idle_in();
    chk("post_reset_run_count", {29'd0, count}, 32'd1);
    chk("post_reset_run_pc", out_pc, 32'h600);

    $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
    $finish;
  end

endmodule
